// File: rtl/ycbcr_frame_ctrl.sv
// Frame gate in front of the RGB->YCbCr converter: admits whole frames on command, reports completion.
// Optional size checker built when YCBCR_FRAME_CTRL_CHK_EN is defined.
module ycbcr_frame_ctrl #(
    parameter int H_ACT    = 640,
    parameter int V_ACT    = 480,
    parameter int PIPE_LAT = 3
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic [7:0]  frame_num,
    input  logic        per_frame_vsync,
    input  logic        per_frame_href,
    input  logic        per_frame_clken,
    input  logic [23:0] pix_data_in,
    output logic        csc_frame_vsync,
    output logic        csc_frame_href,
    output logic        csc_frame_clken,
    output logic [23:0] csc_pix_data,
    output logic        busy,
    output logic        frame_done,
    output logic [7:0]  frame_cnt,
    output logic        size_err,
    output logic [11:0] h_meas,
    output logic [11:0] v_meas
);

    localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT + 1) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_LAT);

    if (H_ACT < 1 || H_ACT > 4095 || V_ACT < 1 || V_ACT > 4095 || PIPE_LAT < 0) begin : g_param_chk
        $error("ycbcr_frame_ctrl: H_ACT/V_ACT must fit 12-bit counters, PIPE_LAT must be >= 0");
    end

    typedef enum logic [1:0] {IDLE, ARM, ACTIVE, DRAIN} state_t;

    state_t          state;
    logic            vsync_d;
    logic            stop_req;
    logic [7:0]      frame_num_r;
    logic [DW-1:0]   drain_cnt;
    logic            vs_rise, vs_fall, pass, start_acc, run_done;

    assign vs_rise   = per_frame_vsync & ~vsync_d;
    assign vs_fall   = ~per_frame_vsync & vsync_d;
    assign pass      = (state == ACTIVE) | ((state == ARM) & vs_rise);
    assign start_acc = (state == IDLE) & start & ~stop;
    assign run_done  = (frame_num_r != '0) && (frame_cnt == frame_num_r);

    // busy is cleared from IDLE, so it stays high through the frame_done cycle and drops one cycle later
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state           <= IDLE;
            vsync_d         <= 1'b0;
            stop_req        <= 1'b0;
            frame_num_r     <= '0;
            drain_cnt       <= '0;
            busy            <= 1'b0;
            frame_done      <= 1'b0;
            frame_cnt       <= '0;
            csc_frame_vsync <= 1'b0;
            csc_frame_href  <= 1'b0;
            csc_frame_clken <= 1'b0;
            csc_pix_data    <= '0;
        end else begin
            vsync_d         <= per_frame_vsync;
            frame_done      <= 1'b0;
            csc_frame_vsync <= per_frame_vsync & pass;
            csc_frame_href  <= per_frame_href & pass;
            csc_frame_clken <= per_frame_clken & pass;
            csc_pix_data    <= pass ? pix_data_in : '0;
            case (state)
                IDLE: begin
                    if (start_acc) begin
                        state       <= ARM;
                        busy        <= 1'b1;
                        frame_cnt   <= '0;
                        stop_req    <= 1'b0;
                        frame_num_r <= frame_num;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ARM: begin
                    // a frame whose first cycle is already forwarded always completes
                    if (vs_rise) begin
                        state <= ACTIVE;
                        if (stop) stop_req <= 1'b1;
                    end else if (stop || stop_req) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (stop) stop_req <= 1'b1;
                    if (vs_fall) begin
                        state     <= DRAIN;
                        frame_cnt <= frame_cnt + 8'd1;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    if (stop) stop_req <= 1'b1;
                    if (drain_cnt == DRAIN_LAST) begin
                        frame_done <= 1'b1;
                        state      <= (stop_req || stop || run_done) ? IDLE : ARM;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef YCBCR_FRAME_CTRL_CHK_EN
    localparam logic [11:0] H_EXP = 12'(H_ACT);
    localparam logic [11:0] V_EXP = 12'(V_ACT);

    logic        href_d, href_fall;
    logic [11:0] h_cnt, v_cnt, v_nxt;

    assign href_fall = ~per_frame_href & href_d;

    always_comb begin
        v_nxt = v_cnt;
        if (href_fall && v_cnt != '1) v_nxt = v_cnt + 12'd1;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            href_d   <= 1'b0;
            h_cnt    <= '0;
            v_cnt    <= '0;
            h_meas   <= '0;
            v_meas   <= '0;
            size_err <= 1'b0;
        end else begin
            href_d <= per_frame_href;
            if (start_acc) size_err <= 1'b0;
            if (state == ARM && vs_rise) begin
                h_cnt <= '0;
                v_cnt <= '0;
            end else if (state == ACTIVE) begin
                if (href_fall) begin
                    h_meas <= h_cnt;
                    h_cnt  <= '0;
                    if (h_cnt != H_EXP) size_err <= 1'b1;
                end else if (per_frame_href && per_frame_clken && h_cnt != '1) begin
                    h_cnt <= h_cnt + 12'd1;
                end
                if (vs_fall) begin
                    v_meas <= v_nxt;
                    v_cnt  <= '0;
                    if (v_nxt != V_EXP) size_err <= 1'b1;
                end else begin
                    v_cnt <= v_nxt;
                end
            end
        end
    end
`else
    assign size_err = 1'b0;
    assign h_meas   = '0;
    assign v_meas   = '0;
`endif

endmodule

// File: tb/tb_ycbcr_frame_ctrl.sv
// Self-checking bench for ycbcr_frame_ctrl: scoreboard on the csc_* stream plus control/timing checks.
module tb_ycbcr_frame_ctrl;

    localparam int H = 8;
    localparam int V = 4;
    localparam int P = 3;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        start = 1'b0, stop = 1'b0;
    logic [7:0]  frame_num = '0;
    logic        per_frame_vsync = 1'b0, per_frame_href = 1'b0, per_frame_clken = 1'b0;
    logic [23:0] pix_data_in = '0;
    logic        csc_frame_vsync, csc_frame_href, csc_frame_clken;
    logic [23:0] csc_pix_data;
    logic        busy, frame_done, size_err;
    logic [7:0]  frame_cnt;
    logic [11:0] h_meas, v_meas;

    ycbcr_frame_ctrl #(.H_ACT(H), .V_ACT(V), .PIPE_LAT(P)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .stop(stop),
        .frame_num(frame_num), .per_frame_vsync(per_frame_vsync),
        .per_frame_href(per_frame_href), .per_frame_clken(per_frame_clken),
        .pix_data_in(pix_data_in), .csc_frame_vsync(csc_frame_vsync),
        .csc_frame_href(csc_frame_href), .csc_frame_clken(csc_frame_clken),
        .csc_pix_data(csc_pix_data), .busy(busy), .frame_done(frame_done),
        .frame_cnt(frame_cnt), .size_err(size_err), .h_meas(h_meas), .v_meas(v_meas)
    );

    always #5 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int drv_cyc = 0;
    int last_vf = 0;
    int fd_cyc  = 0;
    int fd_cnt  = 0;
    logic fd_busy = 1'b0;
    logic [26:0] exp_q[$];

    typedef struct {
        bit st;
        bit sp;
        bit exp_busy;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // one input cycle; expected converter-side value queued for the following edge
    task automatic drive(input logic vs, input logic hs, input logic ck,
                         input bit adm, input bit st, input bit sp);
        logic [23:0] pix;
        @(negedge sys_clk);
        drv_cyc = cyc;
        pix = 24'($urandom);
        start = st;
        stop = sp;
        per_frame_vsync = vs;
        per_frame_href = hs;
        per_frame_clken = ck;
        pix_data_in = pix;
        exp_q.push_back(adm ? {vs, hs, ck, pix} : 27'd0);
    endtask

    task automatic send_frame(input int nl, input int last_len, input bit adm,
                              input int st_line, input int sp_line);
        int len;
        drive(1, 0, 0, adm, 0, 0);
        for (int l = 0; l < nl; l++) begin
            drive(1, 0, 0, adm, l == st_line, l == sp_line);
            drive(1, 0, 0, adm, 0, 0);
            len = (l == nl - 1) ? last_len : H;
            for (int i = 0; i < len; i++) begin
                if (i == 3) drive(1, 1, 0, adm, 0, 0);
                drive(1, 1, 1, adm, 0, 0);
            end
        end
        drive(1, 0, 0, adm, 0, 0);
        drive(1, 0, 0, adm, 0, 0);
        drive(0, 0, 0, adm, 0, 0);
        last_vf = drv_cyc;
        repeat (8) drive(0, 0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        logic [26:0] e;
        forever begin
            @(posedge sys_clk);
            #1;
            cyc++;
            if (frame_done === 1'b1) begin
                fd_cyc  = cyc;
                fd_busy = busy;
                fd_cnt++;
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("csc_stream", {csc_frame_vsync, csc_frame_href, csc_frame_clken, csc_pix_data}, e);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin : stim
        int fd0;
        tbl[0] = '{1, 1, 0};
        tbl[1] = '{0, 0, 0};
        tbl[2] = '{1, 0, 1};
        tbl[3] = '{0, 0, 1};
        tbl[4] = '{0, 1, 0};
        tbl[5] = '{0, 1, 0};
        tbl[6] = '{1, 0, 1};
        tbl[7] = '{1, 0, 1};
        tbl[8] = '{0, 1, 0};

        repeat (3) @(posedge sys_clk);
        #1;
        chk("reset_outputs", {csc_frame_vsync, csc_frame_href, csc_frame_clken, csc_pix_data,
                              busy, frame_done, frame_cnt, size_err, h_meas, v_meas}, 64'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // single shot: only the first of three frames passes
        frame_num = 8'd1;
        drive(0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0);
        fd0 = fd_cnt;
        send_frame(V, H, 1, -1, -1);
        chk("t1_done_latency", fd_cyc - last_vf, P + 2);
        chk("t1_frame_cnt", frame_cnt, 1);
        chk("t1_done_count", fd_cnt - fd0, 1);
        chk("t1_busy_at_done", fd_busy, 1);
        chk("t1_busy_after", busy, 0);
        send_frame(V, H, 0, -1, -1);
        send_frame(V, H, 0, -1, -1);
        chk("t1_no_more_done", fd_cnt - fd0, 1);
        chk("t1_frame_cnt_hold", frame_cnt, 1);

        // start mid-frame: current frame blocked, next one passes
        fd0 = fd_cnt;
        send_frame(V, H, 0, 2, -1);
        chk("t2_armed_busy", busy, 1);
        send_frame(V, H, 1, -1, -1);
        chk("t2_done_latency", fd_cyc - last_vf, P + 2);
        chk("t2_frame_cnt", frame_cnt, 1);
        chk("t2_done_count", fd_cnt - fd0, 1);
        chk("t2_busy_after", busy, 0);

        // continuous run, stop during frame 3
        frame_num = 8'd0;
        drive(0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0);
        fd0 = fd_cnt;
        send_frame(V, H, 1, -1, -1);
        send_frame(V, H, 1, -1, -1);
        chk("t3_busy_running", busy, 1);
        send_frame(V, H, 1, -1, 1);
        chk("t3_done_latency", fd_cyc - last_vf, P + 2);
        chk("t3_frame_cnt", frame_cnt, 3);
        chk("t3_done_count", fd_cnt - fd0, 3);
        chk("t3_busy_after", busy, 0);
        send_frame(V, H, 0, -1, -1);
        chk("t3_blocked_done", fd_cnt - fd0, 3);

        // start/stop control vectors
        fd0 = fd_cnt;
        foreach (tbl[i]) begin
            drive(0, 0, 0, 0, tbl[i].st, tbl[i].sp);
            @(posedge sys_clk);
            #1;
            chk($sformatf("t4_busy_vec%0d", i), busy, tbl[i].exp_busy);
        end
        drive(0, 0, 0, 0, 0, 0);
        chk("t4_no_done", fd_cnt - fd0, 0);

`ifdef YCBCR_FRAME_CTRL_CHK_EN
        frame_num = 8'd1;
        drive(0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0);
        send_frame(V, 7, 1, -1, -1);
        chk("t5_size_err_set", size_err, 1);
        chk("t5_h_meas_short", h_meas, 7);
        chk("t5_v_meas", v_meas, V);
        drive(0, 0, 0, 0, 0, 0);
        chk("t5_size_err_sticky", size_err, 1);
        drive(0, 0, 0, 0, 1, 0);
        @(posedge sys_clk);
        #1;
        chk("t5_size_err_clear", size_err, 0);
        send_frame(V, H, 1, -1, -1);
        chk("t5_size_err_ok", size_err, 0);
        chk("t5_h_meas_ok", h_meas, H);
        chk("t5_v_meas_ok", v_meas, V);
`else
        frame_num = 8'd1;
        drive(0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0);
        send_frame(V, 7, 1, -1, -1);
        chk("t5_size_err_tied", size_err, 0);
        chk("t5_meas_tied", {h_meas, v_meas}, 0);
`endif

        // reset in the middle of an admitted frame
        frame_num = 8'd0;
        drive(0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 0, 0);
        drive(1, 0, 0, 1, 0, 0);
        repeat (4) drive(1, 1, 1, 1, 0, 0);
        @(posedge sys_clk);
        #2;
        chk("t6_busy_before_reset", busy, 1);
        sys_rst_n = 1'b0;
        #1;
        chk("t6_reset_outputs", {csc_frame_vsync, csc_frame_href, csc_frame_clken, csc_pix_data,
                                 busy, frame_done, frame_cnt, size_err, h_meas, v_meas}, 64'd0);
        fd0 = fd_cnt;
        repeat (2) drive(1, 1, 1, 0, 0, 0);
        sys_rst_n = 1'b1;
        repeat (4) drive(1, 1, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        repeat (8) drive(0, 0, 0, 0, 0, 0);
        send_frame(V, H, 0, -1, -1);
        chk("t6_idle_busy", busy, 0);
        chk("t6_no_done", fd_cnt - fd0, 0);
        chk("t6_frame_cnt", frame_cnt, 0);

        @(posedge sys_clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ycbcr_frame_ctrl.md
# ycbcr_frame_ctrl

Frame-level controller placed in front of the RGB-to-YCbCr/gray conversion pipeline. Admits only whole camera frames into the converter on host command (single-shot count or continuous), blanks the converter input between admitted frames, waits for the pipeline to drain, and reports frame completion. Optionally measures each admitted frame's active size against the expected resolution.

## Interface
- H_ACT, 640, expected active pixels per line
- V_ACT, 480, expected active lines per frame
- PIPE_LAT, 3, converter latency in cycles (input-to-output register stages)
- sys_clk  in  1  system clock; all logic on rising edge
- sys_rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begin capture run
- stop  in  1  one-cycle pulse; end run at the next frame boundary
- frame_num  in  8  frames per run, sampled on accepted start; 0 = continuous
- per_frame_vsync  in  1  camera vsync, high for the whole frame
- per_frame_href  in  1  camera line valid
- per_frame_clken  in  1  camera pixel strobe
- pix_data_in  in  24  RGB888 pixel
- csc_frame_vsync / csc_frame_href / csc_frame_clken  out  1 each  gated sync to converter
- csc_pix_data  out  24  gated pixel to converter
- busy  out  1  high in any state except IDLE
- frame_done  out  1  one-cycle pulse after an admitted frame has left the converter
- frame_cnt  out  8  admitted frames completed this run
- size_err  out  1  sticky resolution mismatch
- h_meas, v_meas  out  12 each  size of the last admitted frame

## Operation
- States: IDLE, ARM, ACTIVE, DRAIN.
- Edges: vs_rise = per_frame_vsync & ~vsync_d; vs_fall = ~per_frame_vsync & vsync_d; vsync_d is a 1-cycle register.
- IDLE: start -> ARM; clears frame_cnt, size_err, stop_req; latches frame_num. start and stop in the same cycle: stop wins, remain IDLE. stop alone ignored.
- ARM: vs_rise -> ACTIVE. stop (or pending stop_req) -> IDLE. A start arriving mid-frame (vsync already high) waits for the next rising edge. Partial frames are never admitted.
- ACTIVE: vs_fall -> DRAIN; frame_cnt increments on that cycle. stop sets stop_req only; the frame completes.
- DRAIN: counts PIPE_LAT+1 cycles, then pulses frame_done and leaves DRAIN. Exit to IDLE if stop_req is set or (frame_num != 0 and frame_cnt == frame_num); otherwise to ARM.
- start outside IDLE is ignored. stop in DRAIN sets stop_req.
- pass = (state==ACTIVE) | (state==ARM & vs_rise). Each csc_* output is the registered value of per_* & pass; when pass is low, all csc_* outputs are 0.
- Continuous mode: frame_cnt wraps from 255 to 0 and the run never self-terminates.

## Timing
- Reset: state IDLE; every output 0 (csc_*, busy, frame_done, frame_cnt, size_err, h_meas, v_meas); stop_req 0.
- csc_* are delayed 1 cycle from per_*; the first forwarded cycle is the vs_rise cycle.
- frame_done asserts PIPE_LAT+2 cycles after the vs_fall cycle.
- busy rises the cycle after an accepted start and falls the cycle after frame_done on a terminating frame. On stop in ARM, busy falls the cycle after stop.
- Reset asserted mid-frame returns everything to reset values immediately. After release the block sits in IDLE. An in-flight frame is abandoned, and csc_* are already 0.

## Configuration
- YCBCR_FRAME_CTRL_CHK_EN defined: size checking is built.
  - h counter counts href & clken while ACTIVE; it captures into h_meas and compares to H_ACT on each href falling edge.
  - v counter counts href falling edges; it captures into v_meas and compares to V_ACT on vs_fall.
  - Any mismatch sets size_err, which holds until the next accepted start. Counters are 12 bits and saturate at 4095.
- Not defined: no counters are built; size_err, h_meas and v_meas are tied to 0. Ports are unchanged.

## Test plan
- Single shot: H_ACT=8, V_ACT=4, PIPE_LAT=3, frame_num=1, three frames sent -> only frame 1 appears on csc_*; frame_done fires 5 cycles after its vs_fall; frame_cnt=1; busy drops; frames 2-3 yield csc_* all 0.
- Mid-frame start: start issued while vsync is high and two lines are already sent -> that frame is blocked; the next frame passes bit-exact with 1-cycle delay.
- Continuous with stop: frame_num=0, stop pulsed in the middle of frame 3 -> frame 3 is forwarded fully; frame_done fires; IDLE; frame_cnt=3; frame 4 is blocked.
- Start/stop collision: start and stop in the same cycle while IDLE -> busy stays 0. stop while ARM -> IDLE next cycle with no frame_done.
- Size check (macro on): a frame with one 7-pixel line -> size_err=1, h_meas=7. A following correct run after a new start -> size_err=0, h_meas=8, v_meas=4.
- Reset mid-ACTIVE: sys_rst_n low for 2 cycles -> all outputs 0 immediately; after release the block stays IDLE until start.
